// File: rtl/if_fetch.sv
// if_fetch: PC owner and instruction-memory request front end.
// Optional stall cycle counter enabled by `define IF_PERF_CNT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        b_flag_i,
  input  logic [31:0] b_target_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_req_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH
  } state_t;

  state_t      r_state, w_state;
  logic        r_req, w_req;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_inst, w_inst;
  logic        r_valid, w_valid;
  logic [31:0] r_redir, w_redir;
  logic [31:0] w_tgt;
  logic        w_slot_free;

  assign w_tgt       = b_target_addr_i & ~32'h3;
  assign w_slot_free = !r_valid || !stall_i;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= 32'h0;
      r_pc    <= 32'h0;
      r_inst  <= 32'h0;
      r_valid <= 1'b0;
      r_redir <= 32'h0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_addr  <= w_addr;
      r_pc    <= w_pc;
      r_inst  <= w_inst;
      r_valid <= w_valid;
      r_redir <= w_redir;
    end
  end

  // Next-state: fetch sequencing, slot fill, redirect and flush
  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_addr  = r_addr;
    w_pc    = r_pc;
    w_inst  = r_inst;
    w_valid = r_valid;
    w_redir = r_redir;
    unique case (r_state)
      S_IDLE: begin
        w_state = S_FETCH;
        w_req   = 1'b1;
        w_addr  = b_flag_i ? w_tgt : RESET_PC;
        w_valid = 1'b0;
      end
      S_FETCH: begin
        if (mem_ack_i) begin
          if (b_flag_i) begin
            w_addr  = w_tgt;
            w_valid = 1'b0;
          end else if (w_slot_free) begin
            w_pc    = r_addr;
            w_inst  = mem_rdata_i;
            w_valid = 1'b1;
            w_addr  = r_addr + 32'd4;
          end
        end else begin
          if (b_flag_i) begin
            w_redir = w_tgt;
            w_valid = 1'b0;
            w_state = S_FLUSH;
          end else if (r_valid && !stall_i) begin
            w_valid = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        w_valid = 1'b0;
        if (mem_ack_i) begin
          w_addr  = b_flag_i ? w_tgt : r_redir;
          w_state = S_FETCH;
        end else if (b_flag_i) begin
          w_redir = w_tgt;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_addr;
  assign pc_o         = r_pc;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign stall_req_o  = r_req && !mem_ack_i;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles spent waiting on memory
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 32'h0;
    end else if (stall_req_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed checks of if_fetch with RESET_PC=0x100.
// Memory returns data equal to the requested address.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        b_flag_i;
  logic [31:0] b_target_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_req_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt_o;
`endif

  int tests;
  int fails;

  if_fetch #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .b_flag_i       (b_flag_i),
    .b_target_addr_i(b_target_addr_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o),
    .stall_req_o    (stall_req_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_stall_cnt_o(fetch_stall_cnt_o)
`endif
  );

  assign mem_rdata_i = mem_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'h0, mem_req_o}, 32'h0);
    chk({tag, "_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
    chk({tag, "_sreq"}, {31'h0, stall_req_o}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_cnt"}, fetch_stall_cnt_o, 32'h0);
`endif
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc,
                          input logic v, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'h0, inst_valid_o}, {31'h0, v});
    if (v) begin
      chk({tag, "_pc"}, pc_o, pc);
      chk({tag, "_inst"}, inst_o, pc);
    end
    chk({tag, "_addr"}, mem_addr_o, addr);
    chk({tag, "_req"}, {31'h0, mem_req_o}, 32'h1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    stall_i = 1'b0;
    b_flag_i = 1'b0;
    b_target_addr_i = 32'h0;
    mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");

    rst = 1'b1;
    @(negedge clk);
    chk_slot("first_req", 32'h0, 1'b0, 32'h100);

    mem_ack_i = 1'b1;
    @(negedge clk);
    chk_slot("ack100", 32'h100, 1'b1, 32'h104);
    @(negedge clk);
    chk_slot("ack104", 32'h104, 1'b1, 32'h108);

    mem_ack_i = 1'b0;
    #1;
    chk("wait1_sreq", {31'h0, stall_req_o}, 32'h1);
    @(negedge clk);
    chk_slot("wait1", 32'h0, 1'b0, 32'h108);
    chk("wait2_sreq", {31'h0, stall_req_o}, 32'h1);
    @(negedge clk);
    chk("wait3_sreq", {31'h0, stall_req_o}, 32'h1);
    @(negedge clk);
    mem_ack_i = 1'b1;
    #1;
    chk("ackback_sreq", {31'h0, stall_req_o}, 32'h0);
    @(negedge clk);
    chk_slot("ack108", 32'h108, 1'b1, 32'h10C);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", fetch_stall_cnt_o, 32'd3);
`endif

    stall_i = 1'b1;
    @(negedge clk);
    chk_slot("stall1", 32'h108, 1'b1, 32'h10C);
    @(negedge clk);
    chk_slot("stall2", 32'h108, 1'b1, 32'h10C);
    stall_i = 1'b0;
    @(negedge clk);
    chk_slot("unstall", 32'h10C, 1'b1, 32'h110);

    mem_ack_i = 1'b0;
    b_flag_i = 1'b1;
    b_target_addr_i = 32'h203;
    @(negedge clk);
    chk_slot("br_flush", 32'h0, 1'b0, 32'h110);
    b_flag_i = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk_slot("br_tgt", 32'h0, 1'b0, 32'h200);

    mem_ack_i = 1'b0;
    b_flag_i = 1'b1;
    b_target_addr_i = 32'h300;
    @(negedge clk);
    b_target_addr_i = 32'h400;
    @(negedge clk);
    chk_slot("br2_hold", 32'h0, 1'b0, 32'h200);
    b_flag_i = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk_slot("br2_tgt", 32'h0, 1'b0, 32'h400);
    @(negedge clk);
    chk_slot("ack400", 32'h400, 1'b1, 32'h404);

    b_flag_i = 1'b1;
    b_target_addr_i = 32'h50D;
    @(negedge clk);
    chk_slot("br_ack", 32'h0, 1'b0, 32'h50C);

    b_flag_i = 1'b0;
    mem_ack_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    chk_slot("rel_req", 32'h0, 1'b0, 32'h100);

    mem_ack_i = 1'b1;
    b_flag_i = 1'b1;
    b_target_addr_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_slot("wrap_tgt", 32'h0, 1'b0, 32'hFFFF_FFFC);
    b_flag_i = 1'b0;
    @(negedge clk);
    chk_slot("wrap", 32'hFFFF_FFFC, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
